// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with a 2-FF input synchronizer,
// a mid-bit sampling baud counter and an LSB-first SIPO.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   Serial_In   - asynchronous serial line, idle high
//   rx_data     - last correctly framed word (LSB = first data bit)
//   rx_valid    - one-cycle pulse, rx_data updated this cycle
//   frame_error - one-cycle pulse, stop bit sampled low
//   rx_busy     - high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned W_WORD_LENGHT = 8,
  parameter int unsigned BAUD          = 434,
  parameter int unsigned HALF_BAUD     = 217
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Serial_In,
  output logic [W_WORD_LENGHT-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_error,
  output logic                     rx_busy
);

  localparam int unsigned CW = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam int unsigned BW = (W_WORD_LENGHT > 1) ? $clog2(W_WORD_LENGHT) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BAUD - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W_WORD_LENGHT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic                     sync1_q, sync2_q;
  logic                     rx_s;
  logic [2:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [W_WORD_LENGHT-1:0] sh_q, sh_d;
  logic [W_WORD_LENGHT-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     sample;

  assign rx_s = sync2_q;

  // Mid-bit sample point: half a bit into the start bit, a full bit thereafter.
  always_comb begin
    sample = 1'b0;
    if (state_q == S_START)
      sample = (cnt_q == HALF_LAST);
    else if ((state_q == S_DATA) || (state_q == S_STOP))
      sample = (cnt_q == BAUD_LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (sample) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (sample) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[W_WORD_LENGHT-1:1]};
          // Bit counter saturates at the last bit instead of wrapping.
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start is accepted.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= Serial_In;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
module tb_uart_rx;
  localparam int W    = 8;
  localparam int BAUD = 434;
  localparam int HALF = 217;

  logic         clk = 1'b0;
  logic         rst;
  logic         Serial_In;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_error;
  logic         rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.W_WORD_LENGHT(W), .BAUD(BAUD), .HALF_BAUD(HALF)) dut (
    .clk(clk),
    .rst(rst),
    .Serial_In(Serial_In),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_error(frame_error),
    .rx_busy(rx_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           vcyc_q[$];
  logic [W-1:0] vdat_q[$];
  int           ferr_cnt  = 0;
  int           both_cnt  = 0;
  logic [W-1:0] model_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcyc_q.push_back(cyc);
      vdat_q.push_back(rx_data);
    end
    if (frame_error) ferr_cnt++;
    if (rx_valid && frame_error) both_cnt++;
  end

  task automatic clear_mon();
    vcyc_q.delete();
    vdat_q.delete();
    ferr_cnt = 0;
  endtask

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line is left at the stop-bit level on return.
  task automatic send_frame(input logic [W-1:0] b, input int bl, input logic stop,
                            output int start_cyc);
    Serial_In = 1'b0;
    start_cyc = cyc;
    idle(bl);
    for (int i = 0; i < W; i++) begin
      Serial_In = b[i];
      idle(bl);
    end
    Serial_In = stop;
    idle(bl);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Serial_In = 1'b1;
    idle(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int sc, lat;
    clear_mon();
    send_frame(8'h55, BAUD, 1'b1, sc);
    idle(10);
    model_data = 8'h55;
    total++; if (vcyc_q.size() != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", vcyc_q.size()); end
    if (vcyc_q.size() == 1) begin
      lat = vcyc_q[0] - sc;
      total++; if (vdat_q[0] !== 8'h55) begin bad++; $display("FAIL basic_data got=%h exp=55", vdat_q[0]); end
      total++; if (lat < 4124 || lat > 4126) begin bad++; $display("FAIL basic_latency got=%0d exp=4125+-1", lat); end
    end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    int sc0, sc1, gap;
    clear_mon();
    send_frame(8'hA5, BAUD, 1'b1, sc0);
    send_frame(8'h3C, BAUD, 1'b1, sc1);
    idle(10);
    model_data = 8'h3C;
    total++; if (vcyc_q.size() != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", vcyc_q.size()); end
    if (vcyc_q.size() == 2) begin
      gap = vcyc_q[1] - vcyc_q[0];
      total++; if (vdat_q[0] !== 8'hA5) begin bad++; $display("FAIL b2b_first got=%h exp=a5", vdat_q[0]); end
      total++; if (vdat_q[1] !== 8'h3C) begin bad++; $display("FAIL b2b_second got=%h exp=3c", vdat_q[1]); end
      total++; if (gap < 4338 || gap > 4342) begin bad++; $display("FAIL b2b_gap got=%0d exp=4340", gap); end
    end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_glitch();
    int t0, sc;
    logic busy_seen;
    clear_mon();
    Serial_In = 1'b0;
    t0 = cyc;
    idle(100);
    busy_seen = rx_busy;
    Serial_In = 1'b1;
    while (rx_busy && (cyc - t0) < HALF + 3) idle(1);
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy_seen); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_clear got=%b exp=0 after=%0d", rx_busy, cyc - t0); end
    idle(20);
    total++; if (vcyc_q.size() != 0 || ferr_cnt != 0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", vcyc_q.size(), ferr_cnt); end
    clear_mon();
    send_frame(8'h81, BAUD, 1'b1, sc);
    idle(10);
    model_data = 8'h81;
    total++; if (vcyc_q.size() != 1 || vdat_q.size() != 1 || vdat_q[0] !== 8'h81) begin
      bad++; $display("FAIL glitch_next got=%0d pulses data=%h exp=1 pulse 81", vcyc_q.size(), rx_data);
    end
  endtask

  task automatic test_frame_error();
    int sc;
    clear_mon();
    send_frame(8'h0F, BAUD, 1'b0, sc);
    idle(2000);
    Serial_In = 1'b1;
    idle(BAUD);
    total++; if (ferr_cnt != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    total++; if (vcyc_q.size() != 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", vcyc_q.size()); end
    total++; if (rx_data !== model_data) begin bad++; $display("FAIL ferr_hold got=%h exp=%h", rx_data, model_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b exp=0", rx_busy); end
    clear_mon();
    send_frame(8'h7E, BAUD, 1'b1, sc);
    idle(10);
    model_data = 8'h7E;
    total++; if (vcyc_q.size() != 1 || vdat_q.size() != 1 || vdat_q[0] !== 8'h7E || ferr_cnt != 0) begin
      bad++; $display("FAIL ferr_recover got=%0d pulses data=%h ferr=%0d exp=1 pulse 7e ferr 0", vcyc_q.size(), rx_data, ferr_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] b;
    int sc;
    b = 8'h96;
    clear_mon();
    Serial_In = 1'b0;
    idle(BAUD);
    for (int i = 0; i < 3; i++) begin
      Serial_In = b[i];
      idle(BAUD);
    end
    Serial_In = b[3];
    idle(200);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", rx_busy); end
    rst = 1'b0;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b%b%b exp=000", rx_valid, frame_error, rx_busy);
    end
    Serial_In = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(BAUD);
    model_data = '0;
    total++; if (vcyc_q.size() != 0 || ferr_cnt != 0) begin bad++; $display("FAIL rstmid_partial got=%0d/%0d exp=0/0", vcyc_q.size(), ferr_cnt); end
    clear_mon();
    send_frame(8'hC3, BAUD, 1'b1, sc);
    idle(10);
    model_data = 8'hC3;
    total++; if (vcyc_q.size() != 1 || vdat_q.size() != 1 || vdat_q[0] !== 8'hC3) begin
      bad++; $display("FAIL rstmid_next got=%0d pulses data=%h exp=1 pulse c3", vcyc_q.size(), rx_data);
    end
  endtask

  task automatic test_tolerance();
    int rates[2];
    int sc;
    rates[0] = 425;
    rates[1] = 443;
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      send_frame(8'hE7, rates[r], 1'b1, sc);
      idle(10);
      model_data = 8'hE7;
      total++; if (vcyc_q.size() != 1 || vdat_q.size() != 1 || vdat_q[0] !== 8'hE7) begin
        bad++; $display("FAIL tol_%0d got=%0d pulses data=%h exp=1 pulse e7", rates[r], vcyc_q.size(), rx_data);
      end
      total++; if (ferr_cnt != 0) begin bad++; $display("FAIL tol_ferr_%0d got=%0d exp=0", rates[r], ferr_cnt); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] b;
    int bl, sc;
    logic stop;
    for (int n = 0; n < 4; n++) begin
      b    = W'($urandom_range(0, 255));
      bl   = $urandom_range(427, 441);
      stop = ($urandom_range(0, 3) != 0);
      clear_mon();
      send_frame(b, bl, stop, sc);
      if (!stop) begin
        Serial_In = 1'b1;
        idle(bl);
      end else begin
        idle(10);
      end
      if (stop) begin
        model_data = b;
        total++; if (vcyc_q.size() != 1 || vdat_q.size() != 1 || vdat_q[0] !== b || ferr_cnt != 0) begin
          bad++; $display("FAIL rand_good got=%0d pulses data=%h ferr=%0d exp=1 pulse %h ferr 0", vcyc_q.size(), rx_data, ferr_cnt, b);
        end
      end else begin
        total++; if (vcyc_q.size() != 0 || ferr_cnt != 1 || rx_data !== model_data) begin
          bad++; $display("FAIL rand_ferr got=%0d pulses ferr=%0d data=%h exp=0 pulses ferr 1 data %h", vcyc_q.size(), ferr_cnt, rx_data, model_data);
        end
      end
    end
    total++; if (both_cnt != 0) begin bad++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_tolerance();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
